// File: rtl/intc_sched_pkg.sv
// Shared types and helpers for the interrupt scheduler: FSM states, default
// sizing and a lowest-index-wins priority encoder.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    SERVICE
  } state_t;

  localparam int unsigned N_IRQ_DEF = 4;
  localparam int unsigned VEC_W_DEF = $clog2(N_IRQ_DEF);
  localparam int unsigned PRIO_MAX  = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } prio_t;

  // Walks from the top down so the lowest set index is the last one written.
  function automatic prio_t prio_enc(input logic [PRIO_MAX-1:0] req);
    prio_t r;
    r = '0;
    for (int unsigned i = PRIO_MAX; i > 0; i--) begin
      if (req[i-1]) begin
        r.valid = 1'b1;
        r.idx   = 5'(i - 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intc_sched_if.sv
// Datapath <-> interrupt scheduler bundle. The datapath side is the master,
// the scheduler is the slave.
interface intc_if #(
  parameter int unsigned N_IRQ = intc_pkg::N_IRQ_DEF,
  parameter int unsigned VEC_W = $clog2(N_IRQ)
) ();

  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             ei;
  logic             di;
  logic             reti;
  logic             inhibit;
  logic             int_take;
  logic [VEC_W-1:0] int_vec;
  logic             int_active;
  logic [N_IRQ-1:0] pending;
  logic             gie;

  modport master (
    output irq, mask_we, mask_wdata, ei, di, reti, inhibit,
    input  int_take, int_vec, int_active, pending, gie
  );

  modport slave (
    input  irq, mask_we, mask_wdata, ei, di, reti, inhibit,
    output int_take, int_vec, int_active, pending, gie
  );

endinterface

// File: rtl/intc_sched_sync_edge.sv
// One request line: SYNC_STAGES-deep flop synchronizer followed by a
// rising-edge detector on the synchronized level.
module intc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intc_sched.sv
// Interrupt scheduler: edge-latched pending bits, mask, global enable and a
// fixed-priority IDLE/TAKE/SERVICE FSM. Define INTC_NEST_EN for nested preemption.
module intc_sched
  import intc_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic  clk,
  input logic  reset,
  intc_if.slave bus
);

  localparam int unsigned VEC_W = $clog2(N_IRQ);

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] rise, mask_q, pending_q, eligible, take_clr;
  logic [VEC_W-1:0] vec_q, winner;
  logic             gie_q, gie_d;
  logic             enter_take, reti_ok, preempt, svc_done;
  prio_t            win;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.irq[g]),
      .rise  (rise[g])
    );
  end

  assign eligible = pending_q & mask_q;
  assign win      = prio_enc(PRIO_MAX'(eligible));
  assign winner   = VEC_W'(win.idx);
  assign take_clr = (state_q == TAKE) ? (N_IRQ'(1) << vec_q) : '0;

`ifdef INTC_NEST_EN
  logic [N_IRQ-1:0] isr_q, isr_low;
  prio_t            isr_top;

  // isr only ever gains higher-priority bits, so its lowest set bit is the
  // innermost handler and is the one a reti retires.
  assign isr_low  = isr_q & (-isr_q);
  assign isr_top  = prio_enc(PRIO_MAX'(isr_q));
  assign preempt  = win.valid && (!isr_top.valid || (win.idx < isr_top.idx));
  assign svc_done = ((isr_q & ~isr_low) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      isr_q <= '0;
    end else if (enter_take) begin
      isr_q <= isr_q | (N_IRQ'(1) << winner);
    end else if (reti_ok) begin
      isr_q <= isr_q & ~isr_low;
    end
  end

  assign bus.int_active = |isr_q;
`else
  assign preempt        = 1'b0;
  assign svc_done       = 1'b1;
  assign bus.int_active = (state_q != IDLE);
`endif

  always_comb begin
    state_d    = state_q;
    enter_take = 1'b0;
    reti_ok    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gie_q && win.valid && !bus.inhibit) begin
          state_d    = TAKE;
          enter_take = 1'b1;
        end
      end
      TAKE: state_d = SERVICE;
      SERVICE: begin
        if (bus.reti) begin
          reti_ok = 1'b1;
          if (svc_done) state_d = IDLE;
        end else if (preempt && gie_q && !bus.inhibit) begin
          state_d    = TAKE;
          enter_take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    gie_d = gie_q;
    if (bus.ei || reti_ok) gie_d = 1'b1;
    if (bus.di)            gie_d = 1'b0;
    if (enter_take)        gie_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      gie_q     <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      gie_q     <= gie_d;
      pending_q <= (pending_q & ~take_clr) | rise;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      if (enter_take)  vec_q  <= winner;
    end
  end

  assign bus.int_take = (state_q == TAKE);
  assign bus.int_vec  = vec_q;
  assign bus.pending  = pending_q;
  assign bus.gie      = gie_q;

endmodule

// File: tb/tb_intc_sched.sv
// Self-checking bench for intc_sched: directed scenarios plus random traffic,
// every cycle compared against a queue/stack-based reference model.
`timescale 1ns/1ps
module tb_intc_sched;

  localparam int unsigned N_IRQ       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned VEC_W       = $clog2(N_IRQ);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intc_if #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) bus ();

  intc_sched #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  bit [N_IRQ-1:0] hist[$];
  bit [N_IRQ-1:0] m_pend, m_mask;
  bit             m_gie, m_take;
  int             m_vec;
  int             stack[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit [N_IRQ-1:0] edg, elig, clr;
    bit             serving, reti_ok, take, g;
    int             win;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_gie = 1'b0; m_take = 1'b0; m_vec = 0;
      stack.delete();
      hist.delete();
      for (int i = 0; i <= int'(SYNC_STAGES); i++) hist.push_back('0);
      return;
    end
    // line i is seen rising SYNC_STAGES samples after it was sampled high
    for (int i = 0; i < int'(N_IRQ); i++)
      edg[i] = hist[hist.size()-SYNC_STAGES][i] & ~hist[hist.size()-SYNC_STAGES-1][i];
    elig = m_pend & m_mask;
    win = -1;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) if (elig[i]) win = i;
    serving = (stack.size() != 0) && !m_take;
    reti_ok = serving && bus.reti;
    take = 1'b0;
    if (stack.size() == 0)
      take = m_gie && (win >= 0) && !bus.inhibit;
`ifdef INTC_NEST_EN
    else if (serving && !bus.reti)
      take = m_gie && (win >= 0) && !bus.inhibit && (win < stack[$]);
`endif
    clr = m_take ? bit'(1) << m_vec : '0;
    m_pend = (m_pend & ~clr) | edg;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    g = m_gie;
    if (bus.ei || reti_ok) g = 1'b1;
    if (bus.di)            g = 1'b0;
    if (take)              g = 1'b0;
    m_gie = g;
    if (reti_ok) void'(stack.pop_back());
    if (take) begin
      stack.push_back(win);
      m_vec = win;
    end
    m_take = take;
    hist.push_back(bus.irq);
    void'(hist.pop_front());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("take",    32'(bus.int_take),   32'(m_take));
    check("active",  32'(bus.int_active), 32'(stack.size() != 0));
    check("pending", 32'(bus.pending),    32'(m_pend));
    check("gie",     32'(bus.gie),        32'(m_gie));
    if (m_take) check("vec", 32'(bus.int_vec), 32'(m_vec));
  endtask

  task automatic clear_inputs();
    bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.ei = 1'b0; bus.di = 1'b0; bus.reti = 1'b0; bus.inhibit = 1'b0;
  endtask

  task automatic setup_all_enabled();
    bus.mask_we = 1'b1; bus.mask_wdata = '1; bus.ei = 1'b1;
    cycle();
    bus.mask_we = 1'b0; bus.ei = 1'b0;
    cycle();
  endtask

  task automatic wait_take(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.int_take) seen = 1'b1;
      else cycle();
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_irq(input logic [N_IRQ-1:0] v);
    bus.irq = v; cycle(); bus.irq = '0;
  endtask

  task automatic pulse_reti();
    bus.reti = 1'b1; cycle(); bus.reti = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, takes;
    clear_inputs();
    reset = 1'b1;
    cycle(); cycle();
    check("rst_take",    32'(bus.int_take),   32'd0);
    check("rst_vec",     32'(bus.int_vec),    32'd0);
    check("rst_active",  32'(bus.int_active), 32'd0);
    check("rst_pending", 32'(bus.pending),    32'd0);
    check("rst_gie",     32'(bus.gie),        32'd0);
    reset = 1'b0;
    setup_all_enabled();

    // basic take and latency
    k = cyc;
    pulse_irq(4'b0100);
    wait_take("basic");
    check("basic_latency", 32'(cyc - k), 32'(SYNC_STAGES + 2));
    check("basic_vec", 32'(bus.int_vec), 32'd2);
    check("basic_gie", 32'(bus.gie), 32'd0);
    cycle();
    check("basic_pend2", 32'(bus.pending[2]), 32'd0);
    check("basic_active", 32'(bus.int_active), 32'd1);
    pulse_reti();
    check("basic_reti_active", 32'(bus.int_active), 32'd0);
    check("basic_reti_gie", 32'(bus.gie), 32'd1);

    // priority between simultaneous edges
    pulse_irq(4'b1010);
    wait_take("prio1");
    check("prio_first", 32'(bus.int_vec), 32'd1);
    cycle();
    pulse_reti();
    wait_take("prio2");
    check("prio_second", 32'(bus.int_vec), 32'd3);
    cycle();
    pulse_reti();

    // masked line latches but does not take; inhibit defers
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1110; cycle(); bus.mask_we = 1'b0;
    pulse_irq(4'b0001);
    takes = 0;
    for (int i = 0; i < 6; i++) begin cycle(); takes += int'(bus.int_take); end
    check("mask_no_take", 32'(takes), 32'd0);
    check("mask_pend0", 32'(bus.pending[0]), 32'd1);
    bus.inhibit = 1'b1;
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111; cycle(); bus.mask_we = 1'b0;
    takes = 0;
    for (int i = 0; i < 4; i++) begin cycle(); takes += int'(bus.int_take); end
    check("inhibit_no_take", 32'(takes), 32'd0);
    bus.inhibit = 1'b0;
    wait_take("inhibit");
    check("inhibit_vec", 32'(bus.int_vec), 32'd0);
    cycle();
    pulse_reti();

    // enable conflicts
    bus.ei = 1'b1; bus.di = 1'b1; cycle(); bus.ei = 1'b0; bus.di = 1'b0;
    check("ei_di_gie", 32'(bus.gie), 32'd0);
    pulse_reti();
    check("idle_reti_gie", 32'(bus.gie), 32'd0);
    check("idle_reti_active", 32'(bus.int_active), 32'd0);
    bus.ei = 1'b1; cycle(); bus.ei = 1'b0;

    // new edge on line 2 lands on the clearing edge of its own take
    pulse_irq(4'b0100);
    cycle();
    pulse_irq(4'b0100);
    wait_take("coincide");
    check("coincide_vec", 32'(bus.int_vec), 32'd2);
    cycle();
    check("coincide_pend2", 32'(bus.pending[2]), 32'd1);
    pulse_reti();
    wait_take("coincide2");
    cycle();
    pulse_reti();

    // reset while in service
    pulse_irq(4'b0101);
    wait_take("rstsvc");
    cycle();
    pulse_irq(4'b0001);
    repeat (4) cycle();
    check("rstsvc_pending", 32'(bus.pending), 32'd5);
    check("rstsvc_active", 32'(bus.int_active), 32'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rstsvc_take",    32'(bus.int_take),   32'd0);
    check("rstsvc_vec",     32'(bus.int_vec),    32'd0);
    check("rstsvc_act0",    32'(bus.int_active), 32'd0);
    check("rstsvc_pend0",   32'(bus.pending),    32'd0);
    check("rstsvc_gie0",    32'(bus.gie),        32'd0);

`ifdef INTC_NEST_EN
    setup_all_enabled();
    pulse_irq(4'b1000);
    wait_take("nest_outer");
    check("nest_outer_vec", 32'(bus.int_vec), 32'd3);
    cycle();
    bus.ei = 1'b1; cycle(); bus.ei = 1'b0;
    pulse_irq(4'b0001);
    wait_take("nest_inner");
    check("nest_inner_vec", 32'(bus.int_vec), 32'd0);
    cycle();
    pulse_reti();
    check("nest_reti1_active", 32'(bus.int_active), 32'd1);
    pulse_reti();
    check("nest_reti2_active", 32'(bus.int_active), 32'd0);
`endif

    // random traffic against the model
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic [N_IRQ-1:0] tog;
      for (int i = 0; i < int'(N_IRQ); i++) tog[i] = ($urandom_range(0, 3) == 0);
      bus.irq        = bus.irq ^ tog;
      bus.mask_we    = ($urandom_range(0, 9) == 0);
      bus.mask_wdata = N_IRQ'($urandom());
      bus.ei         = ($urandom_range(0, 4) == 0);
      bus.di         = ($urandom_range(0, 11) == 0);
      bus.reti       = ($urandom_range(0, 5) == 0);
      bus.inhibit    = ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 199) == 0);
      cycle();
    end
    clear_inputs();
    reset = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
